// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the register-stage family: FSM state encoding and a
// width helper used to size bit counters.
package piso_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Returns the number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial line of the PISO stage; master drives words and
// the bit pace, slave is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_last;
    logic             word_done;

    modport master (
        output in_data,
        output in_valid,
        output shift_en,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_last,
        input  word_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  shift_en,
        output in_ready,
        output serial_out,
        output serial_valid,
        output frame_last,
        output word_done
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with decrement enable and zero flag; stops at zero
// rather than wrapping.
module piso_serializer_bit_counter #(
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   dec,
    output logic                   zero
);

    logic [COUNT_WIDTH-1:0] count;

    // A load always wins over a decrement so a back-to-back reload is clean.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes one word per valid/ready handshake and
// shifts it onto serial_out one bit per shift_en edge, streaming without gaps.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    piso_serializer_if.slave    bus
);

    localparam int              COUNT_WIDTH = clog2(WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic             count_zero;
    logic             ready;
    logic             accept;
    logic             advance;
    logic             consume_last;
    logic             word_done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready in SHIFT only when the last bit leaves at this edge, which lets a
    // new word load in the same cycle and keeps the stream gap-free.
    always_comb begin
        state_next   = state;
        ready        = 1'b0;
        advance      = 1'b0;
        consume_last = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_SHIFT: begin
                ready        = count_zero & bus.shift_en;
                advance      = ~count_zero & bus.shift_en;
                consume_last = count_zero & bus.shift_en;
                if (consume_last) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        accept = ready & bus.in_valid;
        if (accept) begin
            state_next = S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= consume_last;
            if (accept) begin
                shift_reg <= bus.in_data;
            end else if (advance) begin
                if (MSB_FIRST) begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                end else begin
                    shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                end
            end
        end
    end

    piso_serializer_bit_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .load_value (LAST_INDEX),
        .dec        (advance),
        .zero       (count_zero)
    );

    assign bus.in_ready     = ready;
    assign bus.serial_valid = (state == S_SHIFT);
    assign bus.serial_out   = (state == S_SHIFT) &
                              (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
    assign bus.frame_last   = (state == S_SHIFT) & count_zero;
    assign bus.word_done    = word_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances, with a
// left-shifting SIPO model on the MSB-first line to recover transmitted words.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   failures  = 0;
    logic [7:0] sipo;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) bus ();
    piso_serializer_if #(.WIDTH(8)) bus_lsb ();

    piso_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    piso_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_lsb.slave)
    );

    always @(posedge clk) begin
        if (!reset_n) begin
            sipo <= 8'h00;
        end else if (bus.serial_valid && bus.shift_en) begin
            sipo <= {sipo[6:0], bus.serial_out};
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] expq[$];
        int sent;
        int done;
        int cycles;

        reset_n         = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.shift_en    = 1'b1;
        bus_lsb.in_data  = 8'h00;
        bus_lsb.in_valid = 1'b0;
        bus_lsb.shift_en = 1'b1;
        repeat (2) @(negedge clk);

        check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("reset_serial_valid", 32'(bus.serial_valid), 32'd0);
        check_output("reset_serial_out", 32'(bus.serial_out), 32'd0);
        check_output("reset_frame_last", 32'(bus.frame_last), 32'd0);
        check_output("reset_word_done", 32'(bus.word_done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Mid-frame reset drops the word without a word_done.
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_output("pre_reset_serial_valid", 32'(bus.serial_valid), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("midreset_serial_valid", 32'(bus.serial_valid), 32'd0);
        check_output("midreset_serial_out", 32'(bus.serial_out), 32'd0);
        check_output("midreset_word_done", 32'(bus.word_done), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("post_reset_no_word_done", 32'(bus.word_done), 32'd0);
            check_output("post_reset_idle", 32'(bus.serial_valid), 32'd0);
        end

        // Single word 0xA5 at full rate; in_data changes after accept are ignored.
        word         = 8'hA5;
        bus.in_data  = word;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hFF;
            end
            check_output("a5_serial_out", 32'(bus.serial_out), 32'(word[7-k]));
            check_output("a5_serial_valid", 32'(bus.serial_valid), 32'd1);
            check_output("a5_frame_last", 32'(bus.frame_last), 32'(k == 7));
            check_output("a5_word_done_low", 32'(bus.word_done), 32'd0);
        end
        @(negedge clk);
        check_output("a5_word_done", 32'(bus.word_done), 32'd1);
        check_output("a5_idle_after", 32'(bus.serial_valid), 32'd0);
        check_output("a5_sipo", 32'(sipo), 32'hA5);
        @(negedge clk);
        check_output("a5_word_done_pulse", 32'(bus.word_done), 32'd0);

        // Back-to-back 0x3C then 0xC3 with in_valid held.
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) bus.in_data = 8'hC3;
            word = (i <= 8) ? 8'h3C : 8'hC3;
            check_output("b2b_serial_out", 32'(bus.serial_out), 32'(word[7-((i-1)%8)]));
            check_output("b2b_serial_valid", 32'(bus.serial_valid), 32'd1);
            check_output("b2b_in_ready", 32'(bus.in_ready), 32'(i == 8 || i == 16));
            check_output("b2b_frame_last", 32'(bus.frame_last), 32'(i == 8 || i == 16));
            check_output("b2b_word_done", 32'(bus.word_done), 32'(i == 9));
            if (i == 9) begin
                check_output("b2b_sipo_first", 32'(sipo), 32'h3C);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_output("b2b_word_done_second", 32'(bus.word_done), 32'd1);
        check_output("b2b_sipo_second", 32'(sipo), 32'hC3);
        check_output("b2b_idle_after", 32'(bus.serial_valid), 32'd0);

        // 0x81 with shift_en every 4th cycle; accept happens with shift_en low.
        word         = 8'h81;
        bus.in_data  = word;
        bus.in_valid = 1'b1;
        bus.shift_en = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) bus.in_valid = 1'b0;
            check_output("paced_serial_out", 32'(bus.serial_out), 32'(word[7-((c-1)/4)]));
            check_output("paced_serial_valid", 32'(bus.serial_valid), 32'd1);
            check_output("paced_word_done_low", 32'(bus.word_done), 32'd0);
            bus.shift_en = (c % 4 == 0);
        end
        @(negedge clk);
        bus.shift_en = 1'b1;
        check_output("paced_word_done", 32'(bus.word_done), 32'd1);
        check_output("paced_sipo", 32'(sipo), 32'h81);

        // LSB-first instance sending 0x01.
        bus_lsb.in_data  = 8'h01;
        bus_lsb.in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus_lsb.in_valid = 1'b0;
            check_output("lsb_serial_out", 32'(bus_lsb.serial_out), 32'(k == 1));
            check_output("lsb_serial_valid", 32'(bus_lsb.serial_valid), 32'd1);
        end
        @(negedge clk);
        check_output("lsb_word_done", 32'(bus_lsb.word_done), 32'd1);

        // Random loopback through the SIPO model with random pacing.
        sent   = 0;
        done   = 0;
        cycles = 0;
        while (done < 1000 && cycles < 40000) begin
            if (bus.word_done) begin
                word = (expq.size() > 0) ? expq.pop_front() : 8'hXX;
                check_output("loopback_word", 32'(sipo), 32'(word));
                done++;
            end
            bus.shift_en = 1'($urandom_range(0, 1));
            bus.in_valid = (sent < 1000);
            bus.in_data  = 8'($urandom_range(0, 255));
            #1;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(bus.in_data);
                sent++;
            end
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
        check_output("loopback_completed", 32'(done), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
